// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// parity mode selectors and the parity-check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Data is zero-extended to 8 bits; zeros do not change the XOR reduction.
    function automatic logic parity_mismatch(input logic [7:0] data,
                                             input logic       par_bit,
                                             input int         mode);
        logic x;
        x = (^data) ^ par_bit;
        if (mode == PAR_ODD) begin
            return ~x;
        end else if (mode == PAR_EVEN) begin
            return x;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through buffer for received words. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic             valid_r;
    logic             full_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Push/pop qualification; a pop frees the slot a same-cycle push needs.
    always_comb begin
        do_pop_s     = rd_en & valid_r;
        do_push_s    = wr_en & (~full_r | do_pop_s);
        overrun      = wr_en & full_r & ~rd_en;
        wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, do_push_s};
        rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, do_pop_s};
    end

    // Pointer and status-flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {(AW + 1){1'b0}};
            rd_ptr_r <= {(AW + 1){1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
            full_r   <= (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = valid_r ? mem_r[rd_ptr_r[AW-1:0]] : {WIDTH{1'b0}};
    assign valid   = valid_r;
    assign full    = full_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, optional parity, sticky error flags
// and a FWFT word buffer on the output side.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DIV        = 326,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rx_valid,
    output logic                 fifo_full,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err
);

    localparam int         DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [DW-1:0]        div_cnt_r;
    logic                 tick_s;
    logic                 rx_meta_r, rx_sync_r;
    rx_state_t            state_r, state_nxt_s;
    logic [3:0]           tcnt_r, tcnt_nxt_s;
    logic [2:0]           bcnt_r, bcnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 par_bad_r, par_bad_nxt_s;
    logic                 push_r, push_nxt_s;
    logic                 frame_set_s, parity_set_s, overrun_s;
    logic                 frame_err_r, parity_err_r, overrun_err_r;

    assign tick_s = (div_cnt_r == DW'(DIV - 1));

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= {DW{1'b0}};
        end else if (tick_s) begin
            div_cnt_r <= {DW{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + DW'(1);
        end
    end

    // Two-flop synchronizer; idles high so reset looks like a quiet line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame FSM: next state, datapath updates and error/push requests.
    always_comb begin
        state_nxt_s   = state_r;
        tcnt_nxt_s    = tcnt_r;
        bcnt_nxt_s    = bcnt_r;
        shift_nxt_s   = shift_r;
        par_bad_nxt_s = par_bad_r;
        push_nxt_s    = 1'b0;
        frame_set_s   = 1'b0;
        parity_set_s  = 1'b0;
        if (tick_s) begin
            case (state_r)
                IDLE: begin
                    if (!rx_sync_r) begin
                        state_nxt_s = START;
                        tcnt_nxt_s  = 4'd0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                START: begin
                    if (tcnt_r == 4'd7) begin
                        if (rx_sync_r) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s   = DATA;
                            tcnt_nxt_s    = 4'd0;
                            bcnt_nxt_s    = 3'd0;
                            par_bad_nxt_s = 1'b0;
                        end
                    end else begin
                        tcnt_nxt_s = tcnt_r + 4'd1;
                    end
                end
                DATA: begin
                    if (tcnt_r == 4'd15) begin
                        shift_nxt_s = {rx_sync_r, shift_r[DATA_BITS-1:1]};
                        tcnt_nxt_s  = 4'd0;
                        if (bcnt_r == LAST_BIT) begin
                            bcnt_nxt_s  = 3'd0;
                            state_nxt_s = (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bcnt_nxt_s = bcnt_r + 3'd1;
                        end
                    end else begin
                        tcnt_nxt_s = tcnt_r + 4'd1;
                    end
                end
                PAR: begin
                    if (tcnt_r == 4'd15) begin
                        par_bad_nxt_s = parity_mismatch(8'(shift_r), rx_sync_r, PARITY);
                        tcnt_nxt_s    = 4'd0;
                        state_nxt_s   = STOP;
                    end else begin
                        tcnt_nxt_s = tcnt_r + 4'd1;
                    end
                end
                STOP: begin
                    if (tcnt_r == 4'd15) begin
                        tcnt_nxt_s = 4'd0;
                        if (rx_sync_r) begin
                            state_nxt_s  = IDLE;
                            parity_set_s = par_bad_r;
                            push_nxt_s   = ~par_bad_r;
                        end else begin
                            frame_set_s = 1'b1;
                            state_nxt_s = BREAK;
                        end
                    end else begin
                        tcnt_nxt_s = tcnt_r + 4'd1;
                    end
                end
                BREAK: begin
                    if (rx_sync_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = BREAK;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM and datapath registers; push_r delays the write by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            tcnt_r    <= 4'd0;
            bcnt_r    <= 3'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            par_bad_r <= 1'b0;
            push_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            tcnt_r    <= tcnt_nxt_s;
            bcnt_r    <= bcnt_nxt_s;
            shift_r   <= shift_nxt_s;
            par_bad_r <= par_bad_nxt_s;
            push_r    <= push_nxt_s;
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err_r   <= 1'b0;
            parity_err_r  <= 1'b0;
            overrun_err_r <= 1'b0;
        end else begin
            frame_err_r   <= frame_set_s  | (frame_err_r   & ~err_clr);
            parity_err_r  <= parity_set_s | (parity_err_r  & ~err_clr);
            overrun_err_r <= overrun_s    | (overrun_err_r & ~err_clr);
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_r),
        .wr_data (shift_r),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .valid   (rx_valid),
        .full    (fifo_full),
        .overrun (overrun_s)
    );

    assign frame_err   = frame_err_r;
    assign parity_err  = parity_err_r;
    assign overrun_err = overrun_err_r;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DIV, default 326, meaning clk cycles per 1/16-bit oversample tick (>=1).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, meaning received-word buffer entries (power of 2, >=2).
REQ-005 SHALL have port clk, input, 1, meaning the single system clock, rising-edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port uart_rx, input, 1, meaning asynchronous serial line, idle high.
REQ-008 SHALL have port rd_en, input, 1, meaning pop the head word this cycle.
REQ-009 SHALL have port rd_data, output, DATA_BITS, meaning head word (first-word-fall-through), LSB first-received.
REQ-010 SHALL have port rx_valid, output, 1, meaning FIFO not empty.
REQ-011 SHALL have port fifo_full, output, 1, meaning FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port err_clr, input, 1, meaning clear all sticky error flags.
REQ-013 SHALL have ports frame_err, parity_err, overrun_err, output, 1 each, meaning sticky error flags.

Function
REQ-014 SHALL pass uart_rx through a two-flop synchronizer before any use.
REQ-015 SHALL generate a one-cycle tick every DIV clk cycles, free-running from reset.
REQ-016 SHALL use FSM states IDLE, START, DATA, PAR, STOP, BREAK.
REQ-017 SHALL leave IDLE for START when synced line is sampled low on a tick, zeroing the 4-bit tick counter.
REQ-018 SHALL, in START, resample at tick count 7; line high -> back to IDLE (glitch, no error); low -> DATA with counter zeroed.
REQ-019 SHALL sample each data/parity/stop bit at tick count 15 of its bit period (bit centre), shifting data LSB first.
REQ-020 SHALL enter PAR after DATA_BITS bits when PARITY!=0, else go directly to STOP.
REQ-021 SHALL flag parity mismatch when XOR of data and parity bit is 0 for odd or 1 for even.
REQ-022 SHALL, on stop bit high with no parity mismatch, push the word into the FIFO on the next clk cycle and return to IDLE.
REQ-023 SHALL, on stop bit low, set frame_err, discard the word, and enter BREAK until the line is sampled high, then IDLE.
REQ-024 SHALL, on parity mismatch with good stop bit, set parity_err and discard the word.
REQ-025 SHALL, on push while full and rd_en low, drop the new word, keep FIFO contents, and set overrun_err.
REQ-026 SHALL accept both push and pop when full and rd_en high in the same cycle, without overrun.
REQ-027 SHALL ignore rd_en while empty; rd_data SHALL then be don't-care.
REQ-028 SHALL update rx_valid and fifo_full on the clk edge following push/pop.
REQ-029 SHALL give error set priority over err_clr in the same cycle.
REQ-030 SHALL wrap FIFO pointers modulo FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.

Reset
REQ-031 SHALL, with reset low, force FSM to IDLE, tick and bit counters to 0, FIFO empty, synchronizer flops to 1.
REQ-032 SHALL hold rx_valid=0, fifo_full=0, frame_err=0, parity_err=0, overrun_err=0, rd_data=0 during and after reset.
REQ-033 SHALL abandon any frame in progress at reset assertion, with no push and no error on release.

Structure
REQ-034 SHALL place the FSM state typedef and parity mode constants (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) in shared package uart_pkg.
REQ-035 SHALL implement the buffer as sub-module uart_fifo, parametrised by width and depth.

Verification
REQ-036 SHALL cover: DIV=1, 8N1, frame 0x55 -> rx_valid rises 1 cycle after stop centre, rd_data=0x55, no errors.
REQ-037 SHALL cover: PARITY=2, 0xA5 sent with parity bit 1 -> parity_err=1, rx_valid stays 0; err_clr pulse -> parity_err=0.
REQ-038 SHALL cover: stop bit held low 3 bit times, then 0x3C -> frame_err=1, 0x3C alone received.
REQ-039 SHALL cover: FIFO_DEPTH=4, five frames 0x01..0x05 with no reads -> fifo_full=1, overrun_err=1, pops return 0x01..0x04.
REQ-040 SHALL cover: 4-cycle low glitch on idle line -> no push, no error; reset pulse mid-DATA -> all outputs 0, next frame received correctly.
